// File: rtl/spi_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_stream_pkg
// Purpose  : Shared register map, bit indices and FSM encoding for spi_stream_ctrl
// Revision : 1.0
// ============================================================================
package spi_stream_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_FILL   = 2'd3;

    localparam int CTRL_SEL  = 0;
    localparam int CTRL_SLOW = 1;
    localparam int CTRL_RXEN = 2;

    localparam int STAT_ACTIVE   = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_RX_EMPTY = 4;
    localparam int STAT_TX_OVF   = 5;
    localparam int STAT_RX_OVF   = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/spi_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_fifo
// Purpose  : Synchronous show-ahead byte FIFO; a push into a full FIFO succeeds
//            when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module spi_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/spi_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_stream_ctrl
// Purpose  : Register-mapped TX/RX FIFO front end and byte sequencer for spictrl
// Revision : 1.0
// ============================================================================
module spi_stream_ctrl
    import spi_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wrdata,
    input  logic       reg_wr,
    input  logic       reg_rd,
    output logic [7:0] reg_rddata,
    output logic [7:0] eng_txdata,
    output logic       eng_txstart,
    input  logic [7:0] eng_rxdata,
    input  logic       eng_busy,
    output logic       eng_slow,
    output logic       spi_ssel_n
);
    state_t     state;
    logic [2:0] ctrl;
    logic       tx_ovf, rx_ovf;
    logic [7:0] fill_cnt;
    logic       sel_eff;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       data_wr, data_rd, ctrl_wr, status_wr, fill_wr;
    logic       launch_tx, launch_fill, rx_push;
    logic       tx_ovf_set, rx_ovf_set, active;
    logic [7:0] status;

    assign data_wr   = reg_wr && (reg_addr == REG_DATA);
    assign data_rd   = reg_rd && (reg_addr == REG_DATA);
    assign ctrl_wr   = reg_wr && (reg_addr == REG_CTRL);
    assign status_wr = reg_wr && (reg_addr == REG_STATUS);
    assign fill_wr   = reg_wr && (reg_addr == REG_FILL);

    // A new byte is only launched from IDLE with the engine quiet; TX data beats fill.
    assign launch_tx   = (state == S_IDLE) && !eng_busy && !tx_empty;
    assign launch_fill = (state == S_IDLE) && !eng_busy && tx_empty && (fill_cnt != 8'd0);
    assign rx_push     = (state == S_DONE) && ctrl[CTRL_RXEN];

    assign tx_ovf_set  = data_wr && tx_full && !launch_tx;
    assign rx_ovf_set  = rx_push && rx_full && !data_rd;

    assign active = (state != S_IDLE) || !tx_empty || (fill_cnt != 8'd0);
    assign status = {1'b0, rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full, active};

    assign eng_slow   = ctrl[CTRL_SLOW];
    assign spi_ssel_n = !sel_eff;

    spi_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .din   (reg_wrdata),
        .pop   (launch_tx),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_head)
    );

    spi_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (eng_rxdata),
        .pop   (data_rd),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= 3'd0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            fill_cnt <= 8'd0;
        end else begin
            if (ctrl_wr) ctrl <= reg_wrdata[2:0];

            // A new overflow in the same cycle as a clear keeps the flag set.
            if (tx_ovf_set)                                 tx_ovf <= 1'b1;
            else if (status_wr && reg_wrdata[STAT_TX_OVF])  tx_ovf <= 1'b0;
            if (rx_ovf_set)                                 rx_ovf <= 1'b1;
            else if (status_wr && reg_wrdata[STAT_RX_OVF])  rx_ovf <= 1'b0;

            if (fill_wr)          fill_cnt <= reg_wrdata;
            else if (launch_fill) fill_cnt <= fill_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            eng_txstart <= 1'b0;
            eng_txdata  <= 8'h00;
            sel_eff     <= 1'b0;
        end else begin
            eng_txstart <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Chip select only tracks CTRL between bytes.
                    sel_eff <= ctrl[CTRL_SEL];
                    if (launch_tx) begin
                        eng_txdata  <= tx_head;
                        eng_txstart <= 1'b1;
                        state       <= S_START;
                    end else if (launch_fill) begin
                        eng_txdata  <= FILL_BYTE;
                        eng_txstart <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT:  if (!eng_busy) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_rddata = 8'h00;
        case (reg_addr)
            REG_DATA:   reg_rddata = rx_empty ? 8'h00 : rx_head;
            REG_CTRL:   reg_rddata = {5'b00000, ctrl};
            REG_STATUS: reg_rddata = status;
            REG_FILL:   reg_rddata = fill_cnt;
            default:    reg_rddata = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_stream_ctrl
// Purpose  : Scoreboard bench for spi_stream_ctrl with a behavioural spictrl engine
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_stream_ctrl;
    import spi_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] reg_addr   = 2'd0;
    logic [7:0] reg_wrdata = 8'h00;
    logic       reg_wr     = 1'b0;
    logic       reg_rd     = 1'b0;
    logic [7:0] reg_rddata;
    logic [7:0] eng_txdata;
    logic       eng_txstart;
    logic [7:0] eng_rxdata = 8'h00;
    logic       eng_busy;
    logic       eng_slow;
    logic       spi_ssel_n;

    logic       eng_busy_m = 1'b0;
    logic       block_busy = 1'b0;
    int         busy_cnt   = 0;
    logic [7:0] cur_tx     = 8'h00;
    bit         rx_en_m    = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    int errors = 0;
    int checks = 0;

    assign eng_busy = eng_busy_m | block_busy;

    always #5 clk = ~clk;

    spi_stream_ctrl #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_addr   (reg_addr),
        .reg_wrdata (reg_wrdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rddata (reg_rddata),
        .eng_txdata (eng_txdata),
        .eng_txstart(eng_txstart),
        .eng_rxdata (eng_rxdata),
        .eng_busy   (eng_busy),
        .eng_slow   (eng_slow),
        .spi_ssel_n (spi_ssel_n)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Engine model: busy from the cycle after txstart, MISO byte = MOSI ^ 0x99.
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_txstart) begin
                check_eq("txstart_while_busy", {7'b0, eng_busy}, 8'h00);
                check_eq("tx_expected", 8'(tx_exp.size() != 0), 8'h01);
                if (tx_exp.size() != 0) check_eq("tx_byte", eng_txdata, tx_exp.pop_front());
                cur_tx     = eng_txdata;
                eng_busy_m = 1'b1;
                busy_cnt   = eng_slow ? 12 : 4;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    eng_busy_m = 1'b0;
                    eng_rxdata = cur_tx ^ 8'h99;
                    if (rx_en_m && rx_exp.size() < 4) rx_exp.push_back(cur_tx ^ 8'h99);
                end
            end
        end
    end

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_addr = a; reg_wrdata = d; reg_wr = 1'b1;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a; reg_rd = 1'b1;
        #1 d = reg_rddata;
        @(negedge clk);
        reg_rd = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        reg_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic data_read_check(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
        reg_read(REG_DATA, d);
        check_eq(tag, d, e);
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_exp.push_back(d);
        reg_write(REG_DATA, d);
    endtask

    task automatic wait_txstart();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (eng_txstart) seen = 1'b1;
        end
        check_eq("txstart_timeout", {7'b0, seen}, 8'h01);
    endtask

    task automatic wait_idle();
        logic [7:0] s = 8'h01;
        for (int i = 0; i < 400 && s[0]; i++) reg_read(REG_STATUS, s);
        check_eq("idle_timeout", {7'b0, s[0]}, 8'h00);
        check_eq("tx_drained", 8'(tx_exp.size()), 8'h00);
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        busy_cnt = 0; eng_busy_m = 1'b0; block_busy = 1'b0; rx_en_m = 1'b0;
        tx_exp.delete(); rx_exp.delete();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        check_eq("watchdog", 8'h01, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        #1;
        check_eq("rst_txstart", {7'b0, eng_txstart}, 8'h00);
        check_eq("rst_txdata", eng_txdata, 8'h00);
        check_eq("rst_slow", {7'b0, eng_slow}, 8'h00);
        check_eq("rst_ssel_n", {7'b0, spi_ssel_n}, 8'h01);
        apply_reset(3);
        read_check("rst_status", REG_STATUS, 8'h14);
        read_check("rst_fill", REG_FILL, 8'h00);
        read_check("rst_ctrl", REG_CTRL, 8'h00);

        // 1: single byte round trip
        reg_write(REG_CTRL, 8'h04); rx_en_m = 1'b1;
        tx_write(8'hA5);
        wait_idle();
        reg_read(REG_DATA, d);
        check_eq("t1_rx", d, 8'h3C);
        void'(rx_exp.pop_front());
        data_read_check("t1_rx_empty");

        // 2: TX overflow while engine blocked
        reg_write(REG_CTRL, 8'h00); rx_en_m = 1'b0;
        block_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tx_exp.push_back(8'hA0 + 8'(i));
            reg_write(REG_DATA, 8'hA0 + 8'(i));
        end
        read_check("t2_status_ovf", REG_STATUS, 8'h33);
        reg_write(REG_STATUS, 8'h20);
        read_check("t2_status_clr", REG_STATUS, 8'h13);
        block_busy = 1'b0;
        wait_idle();

        // 3: fill burst with TX byte inserted mid-burst
        reg_write(REG_CTRL, 8'h02);
        tx_exp.push_back(8'hFF); tx_exp.push_back(8'h5A);
        tx_exp.push_back(8'hFF); tx_exp.push_back(8'hFF);
        reg_write(REG_FILL, 8'd3);
        wait_txstart();
        read_check("t3_fill2", REG_FILL, 8'd2);
        reg_write(REG_DATA, 8'h5A);
        wait_txstart();
        read_check("t3_fill2_after_tx", REG_FILL, 8'd2);
        wait_txstart();
        read_check("t3_fill1", REG_FILL, 8'd1);
        wait_idle();
        read_check("t3_fill0", REG_FILL, 8'd0);

        // 4: RX overflow, in-order drain
        reg_write(REG_CTRL, 8'h04); rx_en_m = 1'b1;
        for (int i = 0; i < 5; i++) tx_write(8'h10 + 8'(i));
        wait_idle();
        read_check("t4_status", REG_STATUS, 8'h4C);
        for (int i = 0; i < 5; i++) data_read_check("t4_rx");
        reg_write(REG_STATUS, 8'h40);
        read_check("t4_status_clr", REG_STATUS, 8'h14);

        // 5: chip select held through a byte
        reg_write(REG_CTRL, 8'h03); rx_en_m = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5_ssel_on", {7'b0, spi_ssel_n}, 8'h00);
        tx_write(8'h77);
        wait_txstart();
        reg_write(REG_CTRL, 8'h02);
        repeat (2) @(negedge clk);
        check_eq("t5_ssel_hold", {7'b0, spi_ssel_n}, 8'h00);
        wait_idle();
        check_eq("t5_ssel_off", {7'b0, spi_ssel_n}, 8'h01);

        // 6: reset during WAIT
        reg_write(REG_CTRL, 8'h07); rx_en_m = 1'b1;
        tx_write(8'hC3);
        wait_txstart();
        repeat (3) @(negedge clk);
        check_eq("t6_ssel_pre", {7'b0, spi_ssel_n}, 8'h00);
        rst = 1'b1;
        #1;
        check_eq("t6_txdata", eng_txdata, 8'h00);
        check_eq("t6_slow", {7'b0, eng_slow}, 8'h00);
        check_eq("t6_ssel_n", {7'b0, spi_ssel_n}, 8'h01);
        apply_reset(3);
        repeat (20) @(negedge clk);
        read_check("t6_status", REG_STATUS, 8'h14);
        data_read_check("t6_rx_empty");
        read_check("t6_fill", REG_FILL, 8'h00);
        check_eq("t6_txstart", {7'b0, eng_txstart}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
